bht_controller: RTL and testbench
=================================

// Module: bht_controller
// PURPOSE
//  Sequences and arbitrates the single-port branch history table (BHT) RAM behind the IFU branch predictor.
//  Initialises every 2-bit counter after reset, and serves predictor lookups from fetch.
//  Buffers execute-stage taken/not-taken feedback in a small FIFO and retires it as read-modify-write updates.
//  Sits between the IFU predictor, the execute feedback path and the BHT RAM (1-cycle read latency).
// PARAMETERS
//  INDEX_W     10     BHT index width; table holds 2**INDEX_W entries
//  FIFO_DEPTH  4      feedback FIFO entries (power of 2, >=2)
//  INIT_CTR    2'b01  counter value written to every entry during init (weakly not-taken)
// PORTS
//  clock_in          in   1        single clock, all state on rising edge
//  reset_n_in        in   1        asynchronous, active-low reset
//  lookup_valid_in   in   1        fetch requests a prediction
//  lookup_index_in   in   INDEX_W  BHT index of the fetched branch
//  lookup_ready_out  out  1        lookup accepted this cycle when valid&ready
//  pred_valid_out    out  1        prediction valid (1 cycle after accept)
//  pred_taken_out    out  1        predicted direction = counter[1]
//  pred_ctr_out      out  2        raw counter read
//  fb_valid_in       in   1        resolved branch feedback
//  fb_index_in       in   INDEX_W  BHT index of resolved branch
//  fb_taken_in       in   1        actual outcome
//  fb_ready_out      out  1        FIFO not full; push when valid&ready
//  mem_en_out        out  1        RAM access strobe
//  mem_we_out        out  1        RAM write enable
//  mem_addr_out      out  INDEX_W  RAM address
//  mem_wdata_out     out  2        RAM write data
//  mem_rdata_in      in   2        RAM read data, valid the cycle after mem_en&!mem_we
//  init_busy_out     out  1        high while INIT sweep runs
// BEHAVIOUR
//  Reset (async, any time, incl. mid-update): state=INIT, init addr=0, FIFO emptied.
//   All outputs 0 except fb_ready_out=1 and init_busy_out=1; a half-done RMW is dropped.
//  FSM states: INIT, IDLE, UPD_WR.
//  INIT: one write/cycle, addr 0..2**INDEX_W-1, wdata=INIT_CTR.
//   lookup_ready_out=0; feedback still accepted into the FIFO.
//   After writing the last addr -> IDLE; init takes exactly 2**INDEX_W cycles.
//  IDLE arbitration (one RAM access/cycle):
//   FIFO full -> update read of head index, lookup_ready_out=0, -> UPD_WR.
//   else lookup_valid_in -> lookup_ready_out=1, read lookup_index_in, stay IDLE.
//   else FIFO non-empty -> update read of head index, -> UPD_WR.
//   else no access.
//  UPD_WR: write sat(mem_rdata_in, head.taken) to head index; pop FIFO; lookup_ready_out=0; -> IDLE.
//   Each update therefore occupies 2 cycles.
//  Saturating counter: taken -> min(ctr+1,3); not-taken -> max(ctr-1,0); 2-bit, no wrap.
//  Lookup latency 1: pred_valid_out registered; pred_taken_out/pred_ctr_out driven from mem_rdata_in while valid.
//  No forwarding: lookup of an index with a queued update returns the pre-update value (stale allowed).
//  FIFO: fb_ready_out = !full, from registered count.
//   Push while full is not accepted even if a pop occurs the same cycle.
//   Simultaneous push+pop when not full keeps count unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  BHT_PERF_CNT_EN defined:
//   adds outputs perf_lookups_out[31:0] (accepted lookups), perf_updates_out[31:0] (completed UPD_WR)
//   and perf_stall_out[31:0] (cycles lookup_valid_in=1 & lookup_ready_out=0).
//   Counters reset to 0, wrap at 2**32.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package core101_bht_pkg: state encodings (INIT/IDLE/UPD_WR);
//   counter constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11; sat_update function.
//  Sub-module bht_fb_fifo: FIFO_DEPTH x {index,taken} sync FIFO exposing push/pop/full/empty/head.
//  Controller = FSM + arbiter + init counter + lookup-valid register.
// TESTING (bench models RAM with 1-cycle read; INDEX_W=4 unless noted)
//  1 Reset release -> init_busy_out high exactly 16 cycles, writes addr 0..15 with 2'b01, then IDLE.
//  2 After init, lookup idx 5 -> accepted, next cycle pred_valid_out=1, pred_ctr_out=01, pred_taken_out=0.
//  3 Feedback idx 5 taken x3 then lookup idx 5 -> ctr 01->10->11->11 (saturates), pred_taken_out=1.
//    Then not-taken x4 -> ctr ends 00, no wrap to 11.
//  4 Continuous lookup_valid_in with 4 feedbacks pushed (FIFO full) -> fb_ready_out=0.
//    lookup_ready_out drops, update drains, fb_ready_out returns 1 next cycle after pop.
//  5 Assert reset_n_in low during UPD_WR -> FIFO empty, state INIT, pred_valid_out=0;
//    entry under update holds INIT_CTR after re-init.
//  6 With BHT_PERF_CNT_EN: 10 lookups, 3 updates -> perf_lookups_out=10, perf_updates_out=3.

Source files
------------

// File: rtl/core101_bht_pkg.sv
// rtl/core101_bht_pkg.sv - BHT controller state encodings, counter constants and saturating update
package core101_bht_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_WR = 2'd2
  } bht_state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // 2-bit counter moves one step toward the outcome and sticks at the rails
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_fb_fifo.sv
// rtl/bht_fb_fifo.sv - synchronous FIFO of {index, taken} branch feedback entries
module bht_fb_fifo #(
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [INDEX_W-1:0] push_index_i,
  input  logic               push_taken_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [INDEX_W-1:0] head_index_o,
  output logic               head_taken_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned DEPTH_I = DEPTH;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH_I[PTR_W:0];

  logic [INDEX_W-1:0] index_q [DEPTH];
  logic [DEPTH-1:0]   taken_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  // Full comes from the registered count, so a pop never frees a slot in the same cycle
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_index_o = index_q[rd_ptr_q];
  assign head_taken_o = taken_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      index_q[wr_ptr_q] <= push_index_i;
      taken_q[wr_ptr_q] <= push_taken_i;
    end
  end

endmodule

// File: rtl/bht_controller.sv
// rtl/bht_controller.sv - BHT RAM sequencer: init sweep, lookup/update arbitration, feedback RMW
// Optional performance counters are built when BHT_PERF_CNT_EN is defined.
module bht_controller
  import core101_bht_pkg::*;
#(
  parameter int unsigned INDEX_W    = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_CTR   = WNT
) (
  input  logic               clock_in,
  input  logic               reset_n_in,
  input  logic               lookup_valid_in,
  input  logic [INDEX_W-1:0] lookup_index_in,
  output logic               lookup_ready_out,
  output logic               pred_valid_out,
  output logic               pred_taken_out,
  output logic [1:0]         pred_ctr_out,
  input  logic               fb_valid_in,
  input  logic [INDEX_W-1:0] fb_index_in,
  input  logic               fb_taken_in,
  output logic               fb_ready_out,
  output logic               mem_en_out,
  output logic               mem_we_out,
  output logic [INDEX_W-1:0] mem_addr_out,
  output logic [1:0]         mem_wdata_out,
  input  logic [1:0]         mem_rdata_in,
  output logic               init_busy_out
`ifdef BHT_PERF_CNT_EN
  ,
  output logic [31:0]        perf_lookups_out,
  output logic [31:0]        perf_updates_out,
  output logic [31:0]        perf_stall_out
`endif
);

  bht_state_e         state_q, state_d;
  logic [INDEX_W-1:0] init_addr_q, init_addr_d;
  logic               pred_valid_q, pred_valid_d;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [INDEX_W-1:0] head_index;
  logic               head_taken;

  logic               lookup_accept;
  logic               mem_en, mem_we;
  logic [INDEX_W-1:0] mem_addr;
  logic [1:0]         mem_wdata;

  bht_fb_fifo #(
    .INDEX_W (INDEX_W),
    .DEPTH   (FIFO_DEPTH)
  ) u_fb_fifo (
    .clk_i        (clock_in),
    .rst_ni       (reset_n_in),
    .push_i       (fb_valid_in),
    .push_index_i (fb_index_in),
    .push_taken_i (fb_taken_in),
    .pop_i        (fifo_pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_index_o (head_index),
    .head_taken_o (head_taken)
  );

  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    lookup_accept = 1'b0;
    fifo_pop      = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      ST_INIT: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = init_addr_q;
        mem_wdata   = INIT_CTR;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A full FIFO outranks fetch so feedback can never be starved
        if (fifo_full) begin
          mem_en   = 1'b1;
          mem_addr = head_index;
          state_d  = ST_UPD_WR;
        end else if (lookup_valid_in) begin
          lookup_accept = 1'b1;
          mem_en        = 1'b1;
          mem_addr      = lookup_index_in;
        end else if (!fifo_empty) begin
          mem_en   = 1'b1;
          mem_addr = head_index;
          state_d  = ST_UPD_WR;
        end
      end
      ST_UPD_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_index;
        mem_wdata = sat_update(mem_rdata_in, head_taken);
        fifo_pop  = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    pred_valid_d = lookup_accept;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= ST_INIT;
      init_addr_q  <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      pred_valid_q <= pred_valid_d;
    end
  end

  // RAM strobes are held off while reset is asserted so an interrupted RMW never lands
  assign mem_en_out    = mem_en & reset_n_in;
  assign mem_we_out    = mem_we & reset_n_in;
  assign mem_addr_out  = reset_n_in ? mem_addr : '0;
  assign mem_wdata_out = reset_n_in ? mem_wdata : '0;

  assign lookup_ready_out = lookup_accept;
  assign fb_ready_out     = ~fifo_full;
  assign init_busy_out    = (state_q == ST_INIT);
  assign pred_valid_out   = pred_valid_q;
  assign pred_ctr_out     = pred_valid_q ? mem_rdata_in : 2'b00;
  assign pred_taken_out   = pred_valid_q & mem_rdata_in[1];

`ifdef BHT_PERF_CNT_EN
  logic [31:0] perf_lookups_q, perf_updates_q, perf_stall_q;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      perf_lookups_q <= '0;
      perf_updates_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_lookups_q <= perf_lookups_q + {31'd0, lookup_accept};
      perf_updates_q <= perf_updates_q + {31'd0, (state_q == ST_UPD_WR)};
      perf_stall_q   <= perf_stall_q + {31'd0, (lookup_valid_in & ~lookup_accept)};
    end
  end

  assign perf_lookups_out = perf_lookups_q;
  assign perf_updates_out = perf_updates_q;
  assign perf_stall_out   = perf_stall_q;
`endif

endmodule

// File: tb/tb_bht_controller.sv
// tb/tb_bht_controller.sv - directed bench for bht_controller with a 16-entry 1-cycle-read RAM model
// Perf counter checks are built when BHT_PERF_CNT_EN is defined.
module tb_bht_controller;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lookup_valid;
  logic [IW-1:0] lookup_index;
  logic          lookup_ready;
  logic          pred_valid, pred_taken;
  logic [1:0]    pred_ctr;
  logic          fb_valid;
  logic [IW-1:0] fb_index;
  logic          fb_taken;
  logic          fb_ready;
  logic          mem_en, mem_we;
  logic [IW-1:0] mem_addr;
  logic [1:0]    mem_wdata;
  logic [1:0]    mem_rdata;
  logic          init_busy;
`ifdef BHT_PERF_CNT_EN
  logic [31:0]   perf_lookups, perf_updates, perf_stall;
`endif

  logic [1:0]    ram [16];
  logic          ram_fill;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  bht_controller #(
    .INDEX_W    (IW),
    .FIFO_DEPTH (4),
    .INIT_CTR   (2'b01)
  ) dut (
    .clock_in         (clk),
    .reset_n_in       (rst_n),
    .lookup_valid_in  (lookup_valid),
    .lookup_index_in  (lookup_index),
    .lookup_ready_out (lookup_ready),
    .pred_valid_out   (pred_valid),
    .pred_taken_out   (pred_taken),
    .pred_ctr_out     (pred_ctr),
    .fb_valid_in      (fb_valid),
    .fb_index_in      (fb_index),
    .fb_taken_in      (fb_taken),
    .fb_ready_out     (fb_ready),
    .mem_en_out       (mem_en),
    .mem_we_out       (mem_we),
    .mem_addr_out     (mem_addr),
    .mem_wdata_out    (mem_wdata),
    .mem_rdata_in     (mem_rdata),
    .init_busy_out    (init_busy)
`ifdef BHT_PERF_CNT_EN
    ,
    .perf_lookups_out (perf_lookups),
    .perf_updates_out (perf_updates),
    .perf_stall_out   (perf_stall)
`endif
  );

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 16; i++) ram[i] <= 2'b11;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [IW-1:0] idx, input logic [1:0] exp, input string tag);
    int n;
    lookup_valid = 1'b1;
    lookup_index = idx;
    #1;
    n = 0;
    while (!lookup_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, lookup_ready, 1);
    tick();
    lookup_valid = 1'b0;
    check({tag, "_pvalid"}, pred_valid, 1);
    check({tag, "_ctr"}, pred_ctr, exp);
    check({tag, "_taken"}, pred_taken, exp[1]);
  endtask

  task automatic push_fb(input logic [IW-1:0] idx, input logic taken);
    int n;
    fb_valid = 1'b1;
    fb_index = idx;
    fb_taken = taken;
    #1;
    n = 0;
    while (!fb_ready && n < 50) begin
      tick();
      n++;
    end
    check("fb_accept", fb_ready, 1);
    tick();
    fb_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, init_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, bad;
    rst_n = 1'b0; ram_fill = 1'b1;
    lookup_valid = 1'b0; lookup_index = '0;
    fb_valid = 1'b0; fb_index = '0; fb_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ram_fill = 1'b0;

    check("rst_init_busy", init_busy, 1);
    check("rst_fb_ready", fb_ready, 1);
    check("rst_lookup_ready", lookup_ready, 0);
    check("rst_pred_valid", pred_valid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // init sweep: one write per cycle, 16 cycles
    rst_n = 1'b1;
    #1;
    cnt = 0; bad = 0;
    while (init_busy && cnt < 100) begin
      if (!(mem_en && mem_we && mem_addr == cnt[3:0] && mem_wdata == 2'b01)) bad++;
      tick();
      cnt++;
    end
    check("init_cycles", cnt, 16);
    check("init_writes", bad, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] != 2'b01) bad++;
    check("init_ram", bad, 0);
    check("idle_no_access", mem_en, 0);

    do_lookup(4'd5, 2'b01, "lk5_init");
    tick();
    check("pred_valid_drop", pred_valid, 0);

    // saturation up then down
    push_fb(4'd5, 1'b1);
    repeat (6) tick();
    do_lookup(4'd5, 2'b10, "lk5_t1");
    push_fb(4'd5, 1'b1);
    push_fb(4'd5, 1'b1);
    repeat (8) tick();
    do_lookup(4'd5, 2'b11, "lk5_sat_hi");
    for (int i = 0; i < 4; i++) push_fb(4'd5, 1'b0);
    repeat (12) tick();
    do_lookup(4'd5, 2'b00, "lk5_sat_lo");
    do_lookup(4'd6, 2'b01, "lk6_untouched");

    // FIFO fills under continuous lookups
    lookup_valid = 1'b1; lookup_index = 4'd3;
    fb_valid = 1'b1; fb_index = 4'd9; fb_taken = 1'b1;
    #1;
    check("fill_lk_ready", lookup_ready, 1);
    check("fill_fb_ready", fb_ready, 1);
    tick();
    repeat (3) tick();
    fb_index = 4'd10; fb_taken = 1'b0;
    #1;
    check("full_fb_ready", fb_ready, 0);
    check("full_lk_ready", lookup_ready, 0);
    check("full_upd_rd_en", mem_en, 1);
    check("full_upd_rd_we", mem_we, 0);
    check("full_upd_rd_addr", mem_addr, 9);
    tick();
    check("updwr_lk_ready", lookup_ready, 0);
    check("updwr_fb_ready", fb_ready, 0);
    check("updwr_we", mem_we, 1);
    check("updwr_addr", mem_addr, 9);
    check("updwr_wdata", mem_wdata, 2'b10);
    tick();
    check("popped_fb_ready", fb_ready, 1);
    check("popped_lk_ready", lookup_ready, 1);
    tick();
    fb_valid = 1'b0;
    #1;
    check("refull_lk_ready", lookup_ready, 0);
    check("refull_fb_ready", fb_ready, 0);
    lookup_valid = 1'b0;
    repeat (12) tick();
    do_lookup(4'd9, 2'b11, "lk9_drained");
    do_lookup(4'd10, 2'b00, "lk10_drained");
    do_lookup(4'd3, 2'b01, "lk3_plain");

    // reset in the middle of an update
    push_fb(4'd12, 1'b1);
    cnt = 0;
    while (!(mem_we && mem_addr == 4'd12) && cnt < 20) begin
      tick();
      cnt++;
    end
    check("upd12_seen", mem_we && mem_addr == 4'd12, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_init_busy", init_busy, 1);
    check("midrst_fb_ready", fb_ready, 1);
    check("midrst_pred_valid", pred_valid, 0);
    check("midrst_mem_en", mem_en, 0);
    tick();
    check("midrst_upd_dropped", ram[12], 2'b01);
    tick();
    rst_n = 1'b1;
    #1;
    wait_init("reinit_done");
    check("reinit_fifo_empty", mem_en, 0);
    do_lookup(4'd12, 2'b01, "lk12_reinit");

`ifdef BHT_PERF_CNT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("perf_rst_lookups", perf_lookups, 0);
    wait_init("perf_init_done");
    for (int i = 0; i < 10; i++) do_lookup(i[IW-1:0], 2'b01, "perf_lk");
    for (int i = 0; i < 3; i++) push_fb(4'd13, 1'b1);
    repeat (10) tick();
    check("perf_lookups", perf_lookups, 10);
    check("perf_updates", perf_updates, 3);
    check("perf_stall", perf_stall, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
